// File: rtl/mult_seq_16bit.sv
// ============================================================================
// mult_seq_16bit: 16x16 sequential shift-add multiplier (17-cycle latency).
// Optional signed mode via macro MULT_SIGNED_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module mult_seq_16bit (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Signed,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] P,
  output logic [15:0] PH
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] mcand_q;
  logic [15:0] mplier_q;
  logic [16:0] acc_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] p_q;
  logic [15:0] ph_q;

  logic [15:0] a_lat_d;
  logic [15:0] b_lat_d;
  logic [16:0] sum_d;
  logic [31:0] prod_d;

`ifdef MULT_SIGNED_EN
  logic neg_q;
  logic neg_d;

  // 0x8000 negates to itself, which reads correctly as magnitude 32768.
  always_comb begin
    a_lat_d = (Signed && A[15]) ? (~A + 16'd1) : A;
    b_lat_d = (Signed && B[15]) ? (~B + 16'd1) : B;
    neg_d   = Signed && (A[15] ^ B[15]);
    prod_d  = neg_q ? (~{acc_q[15:0], mplier_q} + 32'd1) : {acc_q[15:0], mplier_q};
  end
`else
  logic signed_unused;
  assign signed_unused = Signed;

  always_comb begin
    a_lat_d = A;
    b_lat_d = B;
    prod_d  = {acc_q[15:0], mplier_q};
  end
`endif

  assign sum_d = acc_q + {1'b0, (mplier_q[0] ? mcand_q : 16'd0)};

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      mcand_q  <= 16'd0;
      mplier_q <= 16'd0;
      acc_q    <= 17'd0;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= 16'd0;
      ph_q     <= 16'd0;
`ifdef MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            mcand_q  <= a_lat_d;
            mplier_q <= b_lat_d;
            acc_q    <= 17'd0;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
`ifdef MULT_SIGNED_EN
            neg_q    <= neg_d;
`endif
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          // {acc,mplier} shifts right once per step; the add carry lands in acc.
          acc_q    <= {1'b0, sum_d[16:1]};
          mplier_q <= {sum_d[0], mplier_q[15:1]};
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Busy stays up through the Done cycle; it drops at the next IDLE edge.
          p_q     <= prod_d[15:0];
          ph_q    <= prod_d[31:16];
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign P    = p_q;
  assign PH   = ph_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_16bit.sv
// ============================================================================
// tb_mult_seq_16bit: directed self-checking bench for mult_seq_16bit.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mult_seq_16bit;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Signed;
  logic        Busy;
  logic        Done;
  logic [15:0] P;
  logic [15:0] PH;

  int total = 0;
  int bad   = 0;

  mult_seq_16bit dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .Signed (Signed),
    .Busy   (Busy),
    .Done   (Done),
    .P      (P),
    .PH     (PH)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Launches one operation, scrambles A/B after the Start edge, waits for Done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output logic [15:0] p, output logic [15:0] ph, output int lat);
    A = a; B = b; Signed = s; Start = 1'b1;
    step();
    Start = 1'b0;
    A = ~a;
    B = b ^ 16'h5A5A;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (Done === 1'b1) begin
        lat = i;
        break;
      end
    end
    p  = P;
    ph = PH;
    step();
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Start = 1'b0; A = 16'h1111; B = 16'h2222; Signed = 1'b0;
    #1;
    total++;
    if ({Busy, Done, PH, P} !== 34'd0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b PH=%h P=%h, want all zero", Busy, Done, PH, P);
    end
    step();
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic test_basic();
    int early;
    A = 16'h0003; B = 16'h0005; Signed = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy_e1: got %b want 1", Busy);
    end
    early = 0;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (Done !== 1'b0 || Busy !== 1'b1) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL basic_run_window: got %0d bad cycles want 0", early);
    end
    step();
    total++;
    if ({Done, Busy, PH, P} !== {1'b1, 1'b1, 16'h0000, 16'h000F}) begin
      bad++;
      $display("FAIL basic_done_e17: got done=%b busy=%b PH=%h P=%h want 1 1 0000 000F", Done, Busy, PH, P);
    end
    step();
    total++;
    if ({Done, Busy} !== 2'b00) begin
      bad++;
      $display("FAIL basic_idle_e18: got done=%b busy=%b want 0 0", Done, Busy);
    end
    for (int e = 0; e < 3; e++) step();
    total++;
    if ({PH, P} !== 32'h0000_000F) begin
      bad++;
      $display("FAIL basic_hold: got %h want 0000000F", {PH, P});
    end
  endtask

  task automatic test_corners();
    logic [15:0] p, ph;
    int lat;
    run_op(16'hFFFF, 16'hFFFF, 1'b0, p, ph, lat);
    total++;
    if ({ph, p, lat} !== {16'hFFFE, 16'h0001, 32'd17}) begin
      bad++;
      $display("FAIL max_unsigned: got %h lat=%0d want FFFE0001 lat=17", {ph, p}, lat);
    end
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL max_busy_after: got %b want 0", Busy);
    end
    run_op(16'h0000, 16'h1234, 1'b0, p, ph, lat);
    total++;
    if ({ph, p, lat} !== {16'h0000, 16'h0000, 32'd17}) begin
      bad++;
      $display("FAIL zero_operand: got %h lat=%0d want 00000000 lat=17", {ph, p}, lat);
    end
    run_op(16'h1234, 16'h5678, 1'b0, p, ph, lat);
    total++;
    if ({ph, p} !== 32'h0626_0060) begin
      bad++;
      $display("FAIL mixed_pattern: got %h want 06260060", {ph, p});
    end
  endtask

  task automatic test_back_to_back();
    int pulses, first, second;
    A = 16'h0003; B = 16'h0005; Signed = 1'b0; Start = 1'b1;
    pulses = 0; first = -1; second = -1;
    for (int e = 0; e <= 45; e++) begin
      step();
      if (e == 20) Start = 1'b0;
      if (Done === 1'b1) begin
        pulses++;
        if (pulses == 1) first = e;
        else if (pulses == 2) second = e;
      end
    end
    total++;
    if (pulses != 2 || first != 17 || second != 35) begin
      bad++;
      $display("FAIL back_to_back: got pulses=%0d at %0d,%0d want 2 at 17,35", pulses, first, second);
    end
    total++;
    if ({Busy, PH, P} !== {1'b0, 32'h0000_000F}) begin
      bad++;
      $display("FAIL back_to_back_result: got busy=%b %h want 0 0000000F", Busy, {PH, P});
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p, ph;
    int lat, stray;
    A = 16'h0003; B = 16'h0005; Signed = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int e = 1; e <= 8; e++) step();
    Resetn = 1'b0;
    #1;
    total++;
    if ({Busy, Done, PH, P} !== 34'd0) begin
      bad++;
      $display("FAIL reset_mid_async: got busy=%b done=%b %h want 0 0 00000000", Busy, Done, {PH, P});
    end
    stray = 0;
    for (int e = 0; e < 3; e++) begin
      step();
      if (Done !== 1'b0 || Busy !== 1'b0) stray++;
    end
    @(negedge Clock);
    Resetn = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      if (Done !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: got %0d stray cycles want 0", stray);
    end
    run_op(16'h0002, 16'h0002, 1'b0, p, ph, lat);
    total++;
    if ({ph, p, lat} !== {16'h0000, 16'h0004, 32'd17}) begin
      bad++;
      $display("FAIL reset_mid_restart: got %h lat=%0d want 00000004 lat=17", {ph, p}, lat);
    end
  endtask

  task automatic test_signed();
    logic [15:0] p, ph;
    logic [31:0] exp_neg;
    int lat;
`ifdef MULT_SIGNED_EN
    exp_neg = 32'hFFFF_FFFA;
`else
    exp_neg = 32'h0002_FFFA;
`endif
    run_op(16'hFFFE, 16'h0003, 1'b1, p, ph, lat);
    total++;
    if ({ph, p, lat} !== {exp_neg, 32'd17}) begin
      bad++;
      $display("FAIL signed_neg: got %h lat=%0d want %h lat=17", {ph, p}, lat, exp_neg);
    end
    run_op(16'hFFFE, 16'h0003, 1'b0, p, ph, lat);
    total++;
    if ({ph, p} !== 32'h0002_FFFA) begin
      bad++;
      $display("FAIL signed_flag_off: got %h want 0002FFFA", {ph, p});
    end
    run_op(16'h8000, 16'h8000, 1'b1, p, ph, lat);
    total++;
    if ({ph, p} !== 32'h4000_0000) begin
      bad++;
      $display("FAIL signed_min_min: got %h want 40000000", {ph, p});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid();
    test_signed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
